// File: rtl/mem_stage_pkg.sv
// Shared types, encodings and lane helpers for the MEM pipeline stage.
// Covers both the default build and the MEM_STORE_BUFFER_EN store-buffer build.
package mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LD_REQ  = 2'd1,
    S_LD_WAIT = 2'd2,
    S_ST_REQ  = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] b_val;
  } ex_mem_bus_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] wb_value;
  } mem_wb_bus_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend by access size.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      F3_LB:   return {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  return {24'h0, sh[7:0]};
      F3_LH:   return {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  return {16'h0, sh[15:0]};
      F3_LW:   return rdata;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [31:0] b_val, input logic [2:0] f3);
    case (f3)
      F3_SB:   return {4{b_val[7:0]}};
      F3_SH:   return {2{b_val[15:0]}};
      F3_SW:   return b_val;
      default: return b_val;
    endcase
  endfunction

  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_store_buffer_fifo.sv
// Small FIFO of pending stores; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the index bits match.
import mem_stage_pkg::*;

module store_buffer_fifo #(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  sb_entry_t push_data,
  input  logic      pop,
  output sb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sb_entry_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: load/store lane handling, data-cache handshake, stall.
// Define MEM_STORE_BUFFER_EN to retire stores through a SB_DEPTH store buffer.
import mem_stage_pkg::*;

module mem_access_stage #(
  parameter int SB_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  ex_mem_bus_t ex_mem_bus_in,
  input  logic        ex_mem_valid,
  output mem_wb_bus_t mem_wb_bus_out,
  output logic        mem_wb_valid,
  output logic        stall_mem,
  output logic        misaligned,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic        dc_req_we,
  output logic [31:0] dc_req_addr,
  output logic [31:0] dc_req_wdata,
  output logic [3:0]  dc_req_be,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_resp_rdata,
  output mem_state_t  state_dbg
);

  // Handshake: a request transfers on a cycle with dc_req_valid && dc_req_ready;
  // while valid is high and ready low every request field holds steady. The
  // response arrives as a single dc_resp_valid cycle, never in the accept cycle.

  if ((SB_DEPTH < 2) || ((SB_DEPTH & (SB_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("SB_DEPTH must be a power of two, at least 2");
  end

  mem_state_t  state, state_next;
  logic [31:0] addr;
  logic [1:0]  off;
  logic        is_load, is_store, mis_access, load_go, store_go;
  logic        load_blocked, retire, load_done, stall;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata, wb_next;
  logic [3:0]  req_be;

  assign addr       = ex_mem_bus_in.alu_result;
  assign off        = addr[1:0];
  assign is_load    = ex_mem_valid && (ex_mem_bus_in.opcode == OPC_LOAD);
  assign is_store   = ex_mem_valid && (ex_mem_bus_in.opcode == OPC_STORE);
  assign mis_access = (is_load || is_store) && is_misaligned(ex_mem_bus_in.funct3, off);
  assign load_go    = is_load && !mis_access;
  assign store_go   = is_store && !mis_access;

`ifdef MEM_STORE_BUFFER_EN
  sb_entry_t sb_head, sb_in;
  logic      sb_push, sb_pop, sb_full, sb_empty;

  assign sb_in = '{addr: addr, wdata: store_wdata(ex_mem_bus_in.b_val, ex_mem_bus_in.funct3),
                   be: access_be(ex_mem_bus_in.funct3, off)};
  // No store-to-load forwarding: a load waits until every buffered store drained.
  assign load_blocked = !sb_empty;

  store_buffer_fifo #(.DEPTH(SB_DEPTH)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .push      (sb_push),
    .push_data (sb_in),
    .pop       (sb_pop),
    .head      (sb_head),
    .full      (sb_full),
    .empty     (sb_empty)
  );
`else
  assign load_blocked = 1'b0;
`endif

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = addr;
    req_wdata  = store_wdata(ex_mem_bus_in.b_val, ex_mem_bus_in.funct3);
    req_be     = access_be(ex_mem_bus_in.funct3, off);
    stall      = 1'b0;
    load_done  = 1'b0;
`ifdef MEM_STORE_BUFFER_EN
    sb_push    = 1'b0;
    sb_pop     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (load_go) begin
          stall = 1'b1;
          if (!load_blocked) begin
            req_valid  = 1'b1;
            state_next = dc_req_ready ? S_LD_WAIT : S_LD_REQ;
          end
        end else if (store_go) begin
`ifdef MEM_STORE_BUFFER_EN
          // Fullness is judged at cycle start; a same-cycle drain does not help.
          if (sb_full) stall = 1'b1;
          else         sb_push = 1'b1;
`else
          req_valid = 1'b1;
          req_we    = 1'b1;
          if (!dc_req_ready) begin
            stall      = 1'b1;
            state_next = S_ST_REQ;
          end
`endif
        end
      end
      S_LD_REQ: begin
        req_valid = 1'b1;
        stall     = 1'b1;
        if (dc_req_ready) state_next = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (dc_resp_valid) begin
          load_done  = 1'b1;
          state_next = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_ST_REQ: begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        if (dc_req_ready) state_next = S_IDLE;
        else              stall = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
`ifdef MEM_STORE_BUFFER_EN
    if ((state == S_IDLE) && !req_valid && !sb_empty) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = sb_head.addr;
      req_wdata = sb_head.wdata;
      req_be    = sb_head.be;
      sb_pop    = dc_req_ready;
    end
`endif
  end

  // Combinational outputs are forced quiet during reset so an aborted access
  // cannot keep requesting while the bus still holds the old instruction.
  assign dc_req_valid = req_valid && !reset;
  assign dc_req_we    = req_we && !reset;
  assign dc_req_addr  = reset ? 32'h0 : req_addr;
  assign dc_req_wdata = reset ? 32'h0 : req_wdata;
  assign dc_req_be    = reset ? 4'h0 : req_be;
  assign stall_mem    = stall && !reset;
  assign state_dbg    = state;

  assign retire = ex_mem_valid && !stall;

  // Stores and misaligned ops have nothing to write back.
  always_comb begin
    wb_next = addr;
    if (mis_access || is_store) wb_next = 32'h0;
    else if (load_done)         wb_next = load_extend(dc_resp_rdata, ex_mem_bus_in.funct3, off);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      mem_wb_valid   <= 1'b0;
      mem_wb_bus_out <= '0;
      misaligned     <= 1'b0;
    end else begin
      state        <= state_next;
      mem_wb_valid <= retire;
      misaligned   <= mis_access;
      if (retire) begin
        mem_wb_bus_out.instruction <= ex_mem_bus_in.instruction;
        mem_wb_bus_out.opcode      <= ex_mem_bus_in.opcode;
        mem_wb_bus_out.funct3      <= ex_mem_bus_in.funct3;
        mem_wb_bus_out.rd          <= mis_access ? 5'd0 : ex_mem_bus_in.rd;
        mem_wb_bus_out.wb_value    <= wb_next;
      end else begin
        mem_wb_bus_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: op driver, data-cache model,
// retirement scoreboard; the store-buffer scenario runs when MEM_STORE_BUFFER_EN is set.
import mem_stage_pkg::*;

module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clock = 1'b0;
  logic        reset;
  ex_mem_bus_t ex_mem_bus_in;
  logic        ex_mem_valid;
  mem_wb_bus_t mem_wb_bus_out;
  logic        mem_wb_valid, stall_mem, misaligned;
  logic        dc_req_valid, dc_req_ready, dc_req_we;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_be;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;
  mem_state_t  state_dbg;

  int          checks = 0;
  int          failures = 0;
  logic [36:0] exp_q[$];

  int          resp_delay = 0;
  logic [31:0] cache_rdata = 32'h0;
  int          st_cnt = 0;
  int          ld_cnt = 0;
  logic [31:0] last_st_addr, last_st_wdata, last_ld_addr;
  logic [3:0]  last_st_be;

  mem_access_stage dut (
    .clock          (clock),
    .reset          (reset),
    .ex_mem_bus_in  (ex_mem_bus_in),
    .ex_mem_valid   (ex_mem_valid),
    .mem_wb_bus_out (mem_wb_bus_out),
    .mem_wb_valid   (mem_wb_valid),
    .stall_mem      (stall_mem),
    .misaligned     (misaligned),
    .dc_req_valid   (dc_req_valid),
    .dc_req_ready   (dc_req_ready),
    .dc_req_we      (dc_req_we),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_be      (dc_req_be),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_rdata  (dc_resp_rdata),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3[1:0] == 2'b00) return 4'b0001 << off;
    if (f3[1:0] == 2'b01) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] b);
    if (f3[1:0] == 2'b00) return {b[7:0], b[7:0], b[7:0], b[7:0]};
    if (f3[1:0] == 2'b01) return {b[15:0], b[15:0]};
    return b;
  endfunction

  // ---------------- data cache model ----------------
  initial begin : cache_model
    logic pending;
    int   cnt;
    pending = 1'b0;
    cnt = 0;
    dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset && dc_req_valid && dc_req_ready) begin
        if (dc_req_we) begin
          st_cnt++;
          last_st_addr  = dc_req_addr;
          last_st_wdata = dc_req_wdata;
          last_st_be    = dc_req_be;
        end else begin
          ld_cnt++;
          last_ld_addr = dc_req_addr;
          pending = 1'b1;
          cnt = resp_delay;
        end
      end
      @(posedge clock);
      #1;
      if (reset) begin
        pending = 1'b0;
        dc_resp_valid = 1'b0;
      end else if (pending && cnt == 0) begin
        dc_resp_valid = 1'b1;
        dc_resp_rdata = cache_rdata;
        pending = 1'b0;
      end else begin
        dc_resp_valid = 1'b0;
        if (pending) cnt--;
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mem_wb_valid) begin
        if (exp_q.size() > 0)
          check_eq("wb_rd_value", {27'h0, mem_wb_bus_out.rd, mem_wb_bus_out.wb_value},
                   {27'h0, exp_q.pop_front()});
        else
          check_eq("wb_unexpected", 64'(exp_q.size()), 64'd1);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the op's completion cycle.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] bval, input logic [4:0] rd, input int rw,
                        input int rdelay, input logic [31:0] rdata, input logic [36:0] exp,
                        output int stalls, output logic saw_req);
    logic        held, done;
    logic [68:0] ref_req;
    ex_mem_bus_in.instruction = $urandom();
    ex_mem_bus_in.opcode      = opc;
    ex_mem_bus_in.funct3      = f3;
    ex_mem_bus_in.rd          = rd;
    ex_mem_bus_in.alu_result  = addr;
    ex_mem_bus_in.b_val       = bval;
    ex_mem_valid = 1'b1;
    dc_req_ready = (rw == 0);
    resp_delay   = rdelay;
    cache_rdata  = rdata;
    exp_q.push_back(exp);
    stalls = 0; saw_req = 1'b0; held = 1'b0; done = 1'b0; ref_req = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clock);
      if (dc_req_valid) saw_req = 1'b1;
      if (dc_req_valid && !dc_req_ready) begin
        if (held) check_eq("req_stable", 64'(ref_req ^ {dc_req_we, dc_req_addr, dc_req_wdata,
                           dc_req_be}), 64'd0);
        ref_req = {dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be};
        held = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (!stall_mem) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(posedge clock);
      #1;
      dc_req_ready = (cyc + 1 >= rw);
    end
    check_eq("op_completes", 64'(done), 64'd1);
    @(posedge clock);
    #1;
    ex_mem_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int   st;
    logic sr;
    int   base;
    reset = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_bus_in = '0;
    dc_req_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_wb_valid", 64'(mem_wb_valid), 64'd0);
    check_eq("rst_wb_bus", 64'(mem_wb_bus_out.wb_value) | 64'(mem_wb_bus_out.rd), 64'd0);
    check_eq("rst_misaligned", 64'(misaligned), 64'd0);
    check_eq("rst_req_valid", 64'(dc_req_valid), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Pass-through ALU op.
    run_op(OP_ALU, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0, {5'd5, 32'h1234}, st, sr);
    check_eq("alu_stall", 64'(st), 64'd0);
    check_eq("alu_no_req", 64'(sr), 64'd0);

    // Byte loads at the top lane.
    run_op(OP_LOAD, 3'b000, 32'h1003, 32'h0, 5'd6, 0, 0, 32'h80FFFFFF,
           {5'd6, 32'hFFFFFF80}, st, sr);
    check_eq("lb_stall", 64'(st), 64'd1);
    check_eq("lb_addr", 64'(last_ld_addr), 64'h1003);
    run_op(OP_LOAD, 3'b100, 32'h1003, 32'h0, 5'd6, 0, 0, 32'h80FFFFFF,
           {5'd6, 32'h00000080}, st, sr);
    check_eq("lbu_stall", 64'(st), 64'd1);

    // Halfword load with ready held low for 3 cycles.
    run_op(OP_LOAD, 3'b001, 32'h1002, 32'h0, 5'd10, 3, 0, 32'h98765432,
           {5'd10, 32'hFFFF9876}, st, sr);
    check_eq("lh_stall", 64'(st), 64'd4);

    // Misaligned word store.
    base = st_cnt;
    run_op(OP_STORE, 3'b010, 32'h1001, 32'h55, 5'd9, 0, 0, 32'h0, {5'd0, 32'h0}, st, sr);
    check_eq("mis_stall", 64'(st), 64'd0);
    check_eq("mis_no_req", 64'(sr), 64'd0);
    check_eq("mis_pulse", 64'(misaligned), 64'd1);
    @(posedge clock);
    #1;
    check_eq("mis_pulse_end", 64'(misaligned), 64'd0);
    check_eq("mis_no_store", 64'(st_cnt - base), 64'd0);

    // Bubble with a load pattern on the bus: nothing happens.
    ex_mem_bus_in.opcode = OP_LOAD;
    ex_mem_bus_in.funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("bubble_req", 64'(dc_req_valid), 64'd0);
      check_eq("bubble_stall", 64'(stall_mem), 64'd0);
    end
    @(posedge clock);
    #1;

`ifdef MEM_STORE_BUFFER_EN
    // Three SB with ready low: two buffer, third waits for one drain.
    base = st_cnt;
    run_op(OP_STORE, 3'b000, 32'h2002, 32'hFFFFFFAB, 5'd0, 100, 0, 32'h0, {5'd0, 32'h0}, st, sr);
    check_eq("sb1_stall", 64'(st), 64'd0);
    run_op(OP_STORE, 3'b000, 32'h2002, 32'hFFFFFFAB, 5'd0, 100, 0, 32'h0, {5'd0, 32'h0}, st, sr);
    check_eq("sb2_stall", 64'(st), 64'd0);
    run_op(OP_STORE, 3'b000, 32'h2002, 32'hFFFFFFAB, 5'd0, 2, 0, 32'h0, {5'd0, 32'h0}, st, sr);
    check_eq("sb3_stall", 64'(st), 64'd3);
    dc_req_ready = 1'b1;
    for (int i = 0; i < 20 && (st_cnt - base) < 3; i++) @(posedge clock);
    #1;
    check_eq("sb_drained", 64'(st_cnt - base), 64'd3);
    check_eq("sb_be", 64'(last_st_be), 64'h4);
    check_eq("sb_wdata", 64'(last_st_wdata), 64'hABABABAB);
    check_eq("sb_addr", 64'(last_st_addr), 64'h2002);
`else
    // Unbuffered SB, ready low 2 cycles.
    base = st_cnt;
    run_op(OP_STORE, 3'b000, 32'h2002, 32'hFFFFFFAB, 5'd0, 2, 0, 32'h0, {5'd0, 32'h0}, st, sr);
    check_eq("sb_stall", 64'(st), 64'd2);
    check_eq("sb_count", 64'(st_cnt - base), 64'd1);
    check_eq("sb_be", 64'(last_st_be), 64'h4);
    check_eq("sb_wdata", 64'(last_st_wdata), 64'hABABABAB);
`endif

    // Randomised mix.
    for (int n = 0; n < 24; n++) begin
      int          kind, rw, rdl;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] a, w, b;
      logic [4:0]  rd;
`ifdef MEM_STORE_BUFFER_EN
      kind = $urandom_range(0, 1);
`else
      kind = $urandom_range(0, 2);
`endif
      rw  = $urandom_range(0, 2);
      rdl = $urandom_range(0, 2);
      w   = $urandom();
      b   = $urandom();
      rd  = 5'($urandom_range(1, 31));
      case ($urandom_range(0, 2))
        0:       begin f3 = 3'b000; off = 2'($urandom_range(0, 3)); end
        1:       begin f3 = 3'b001; off = {1'($urandom_range(0, 1)), 1'b0}; end
        default: begin f3 = 3'b010; off = 2'b00; end
      endcase
      a = {20'h3000 + 20'($urandom_range(0, 255)), 10'h0, off};
      if (kind == 0) begin
        run_op(OP_ALU, 3'b000, w, 32'h0, rd, rw, rdl, 32'h0, {rd, w}, st, sr);
        check_eq("rnd_alu_stall", 64'(st), 64'd0);
      end else if (kind == 1) begin
        if (f3 != 3'b010 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
        run_op(OP_LOAD, f3, a, 32'h0, rd, rw, rdl, w, {rd, model_load(f3, off, w)}, st, sr);
        check_eq("rnd_ld_stall", 64'(st), 64'(rw + 1 + rdl));
        check_eq("rnd_ld_addr", 64'(last_ld_addr), 64'(a));
      end else begin
        run_op(OP_STORE, f3, a, b, rd, rw, rdl, 32'h0, {rd, 32'h0}, st, sr);
        check_eq("rnd_st_stall", 64'(st), 64'(rw));
        check_eq("rnd_st_be", 64'(last_st_be), 64'(model_be(f3, off)));
        check_eq("rnd_st_wdata", 64'(last_st_wdata), 64'(model_wdata(f3, b)));
      end
    end

    // Reset while waiting for a load response.
    ex_mem_bus_in.opcode     = OP_LOAD;
    ex_mem_bus_in.funct3     = 3'b010;
    ex_mem_bus_in.rd         = 5'd7;
    ex_mem_bus_in.alu_result = 32'h1000;
    resp_delay   = 3;
    cache_rdata  = 32'hDEADBEEF;
    dc_req_ready = 1'b1;
    ex_mem_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_eq("pre_rst_state", 64'(state_dbg), 64'd2);
    reset = 1'b1;
    #1;
    check_eq("arst_req_valid", 64'(dc_req_valid), 64'd0);
    check_eq("arst_stall", 64'(stall_mem), 64'd0);
    check_eq("arst_wb_valid", 64'(mem_wb_valid), 64'd0);
    check_eq("arst_wb_bus", 64'(mem_wb_bus_out.wb_value) | 64'(mem_wb_bus_out.rd), 64'd0);
    check_eq("arst_state", 64'(state_dbg), 64'd0);
    ex_mem_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_op(OP_LOAD, 3'b010, 32'h1004, 32'h0, 5'd8, 0, 0, 32'h13579BDF,
           {5'd8, 32'h13579BDF}, st, sr);
    check_eq("post_rst_stall", 64'(st), 64'd1);

    repeat (3) @(posedge clock);
    #1;
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage, directly downstream of EX: consumes the registered EX/MEM bus (ALU result, store data, opcode, funct3, rd) and produces the registered MEM/WB bus. It issues loads and stores to the data cache over a valid/ready request and valid response handshake. It performs byte-lane alignment and sign/zero extension for loads and lane replication plus byte enables for stores. It raises `stall_mem` to freeze IF/ID/EX while an access is outstanding.

## Interface
- `SB_DEPTH`, default 2: store buffer entries; power of two, ≥2. Used only when `MEM_STORE_BUFFER_EN` is defined.
- `clock  input  1  clock`
- `reset  input  1  asynchronous, active-high`
- `ex_mem_bus_in  input  ex_mem_bus_t  EX/MEM register contents; held stable by upstream while stall_mem=1`
- `ex_mem_valid  input  1  ex_mem_bus_in carries a real instruction`
- `mem_wb_bus_out  output  mem_wb_bus_t  registered: instruction, opcode, rd, funct3, wb_value`
- `mem_wb_valid  output  1  registered; mem_wb_bus_out is a real instruction`
- `stall_mem  output  1  combinational; upstream stages must hold`
- `misaligned  output  1  registered one-cycle pulse on misaligned access`
- `dc_req_valid  output  1`, `dc_req_ready  input  1`, `dc_req_we  output  1`
- `dc_req_addr  output  32`, `dc_req_wdata  output  32`, `dc_req_be  output  4`
- `dc_resp_valid  input  1`, `dc_resp_rdata  input  32  aligned 32-bit word`

## Operation
- Classification: `opcode` LOAD or STORE selects a memory op; any other opcode is pass-through with `wb_value = alu_result`. The address is `alu_result`, and `off = addr[1:0]`.
- Misaligned: a halfword op with `off[0]=1`, or a word op with `off≠0`. No cache request is issued, `misaligned` pulses, and the op retires with `rd=0` and `wb_value=0`.
- Loads:
  - LB: `rdata` lane `off`, sign-extended. LBU: zero-extended.
  - LH: lane `off[1]`, sign-extended. LHU: zero-extended.
  - LW: the full word.
- Stores:
  - `wdata`: SB `{4{b_val[7:0]}}`; SH `{2{b_val[15:0]}}`; SW `b_val`.
  - `be`: SB `4'b0001<<off`; SH `4'b0011<<off`; SW `4'b1111`.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ.
  - **IDLE**, valid load present: drive the request combinationally. On `ready`, go to LD_WAIT; otherwise go to LD_REQ.
  - **LD_REQ**: hold the request until `ready`, then go to LD_WAIT.
  - **LD_WAIT**: on `dc_resp_valid`, register the extended data into MEM/WB and return to IDLE.
  - **Store, no buffer**: IDLE/ST_REQ drive `we=1`. The handshake cycle retires the store.
- `stall_mem = 1` from the cycle a valid memory op appears until, but excluding, its completion cycle. Completion is the response cycle for loads and the handshake cycle for unbuffered stores.
- While `stall_mem=1`, MEM/WB loads a bubble (`mem_wb_valid=0`).
- Request signals are stable while `dc_req_valid && !dc_req_ready`.

## Timing
- Reset values: `mem_wb_bus_out` all zero, `mem_wb_valid=0`, `misaligned=0`, FSM IDLE, store buffer empty, `dc_req_valid=0`. Reset mid-access aborts it immediately. The data cache shares this reset, so no stale response follows.
- Latency:
  - Pass-through and misaligned ops: 1 cycle.
  - Load: 1 + request wait + response wait. Best case is 2 cycles (ready at cycle 0, response at cycle 1).
  - Unbuffered store: 1 + ready wait.
- `dc_resp_valid` is never asserted in the same cycle as the accepting handshake of its request.
- `ex_mem_valid=0`: no request, no stall, bubble forwarded.

## Configuration
- `MEM_STORE_BUFFER_EN`, when defined:
  - Stores go into a SB_DEPTH FIFO of {addr, wdata, be}. An enqueue retires the store in 1 cycle with no stall, provided the buffer is not full at the start of the cycle.
  - A full buffer stalls the store, even if a dequeue happens in the same cycle.
  - The head entry drains to the cache whenever the FSM is IDLE and no load is issuing.
  - A load stalls until the buffer is empty; there is no forwarding.
  - The wrap-around pointers need an extra bit to distinguish full from empty.
- `MEM_STORE_BUFFER_EN` undefined: the FIFO is absent, and stores use the ST_REQ path with stall.

## Structure
- Package `mem_stage_pkg`:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB/SH/SW.
  - FSM state enum.
  - `sb_entry_t` struct.
- Sub-module `store_buffer_fifo`: parameterised FIFO with push/pop/full/empty. It is instantiated only under the macro.

## Test plan
- ALU op, `alu_result=0x1234`, valid → the next cycle `wb_value=0x1234`, `mem_wb_valid=1`, `stall_mem` never asserted.
- LB at addr `0x1003`, rdata `0x80FFFFFF` → `wb_value=0xFFFFFF80`. LBU at the same addr → `0x00000080`. In both, `stall_mem` is high for exactly 1 cycle when ready is immediate and the response comes at cycle 1.
- LH at addr `0x1002` with `dc_req_ready` low for 3 cycles → request fields stable for those cycles, `stall_mem` high for 4 cycles, `wb_value` = sign-extended rdata[31:16].
- SW at addr `0x1001` → `misaligned` pulses, no `dc_req_valid`, retires with `rd=0`.
- With the macro and SB_DEPTH=2, three back-to-back SB to `0x2002` while ready is held low → the first two retire without stall, the third stalls until one drain handshake. `be=4'b0100`, `wdata=0xABABABAB` for `b_val=0xFFFFFFAB`.
- Assert `reset` while in LD_WAIT → `dc_req_valid=0` and all outputs zero immediately; after release, the next load operates normally.
